// File: rtl/memory_bus_arbiter_if.sv
// Generic valid/ready memory bus bundle; LANES parallel request/response ports
// sharing one response data bus.
interface memory_bus_arbiter_if #(
  parameter int LANES = 1,
  parameter int AW    = 32,
  parameter int DW    = 24
);
  logic [LANES-1:0]    req_valid;
  logic [LANES-1:0]    req_ready;
  logic [LANES*AW-1:0] req_address;
  logic [LANES-1:0]    req_write;
  logic [LANES*DW-1:0] req_data;
  logic [LANES-1:0]    resp_valid;
  logic [LANES-1:0]    resp_ready;
  logic [DW-1:0]       resp_data;

  modport master (
    output req_valid, req_address, req_write, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_address, req_write, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Round-robin merge of NUM_MASTERS request ports onto one memory slave, with an
// in-order tag FIFO steering each slave response back to its issuing master.
//
// state | meaning
// IDLE  | no request presented; pick next requester if a tag slot is free
// GRANT | master[grant] drives the slave request until the slave accepts it
module memory_bus_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int DATA_WIDTH      = 24,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  memory_bus_arbiter_if.slave                   m_bus,
  memory_bus_arbiter_if.master                  s_bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding
);
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] grant, grant_nxt;
  logic [GW-1:0] last_grant, last_grant_nxt;
  logic [GW-1:0] pick;
  logic          pick_found;
  int            idx;

  logic [GW-1:0] tag_mem [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [GW-1:0] head;
  logic          push, pop, empty, full;

  assign empty       = (count == '0);
  assign full        = (count == CW'(MAX_OUTSTANDING));
  assign head        = tag_mem[rd_ptr];
  assign outstanding = count;

  // First requester after last_grant, wrapping modulo NUM_MASTERS.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = (int'(last_grant) + i) % NUM_MASTERS;
      if (!pick_found && m_bus.req_valid[GW'(idx)]) begin
        pick       = GW'(idx);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt         = state;
    grant_nxt         = grant;
    last_grant_nxt    = last_grant;
    push              = 1'b0;
    s_bus.req_valid   = '0;
    s_bus.req_address = '0;
    s_bus.req_write   = '0;
    s_bus.req_data    = '0;
    m_bus.req_ready   = '0;
    case (state)
      IDLE: begin
        if (pick_found && !full) begin
          grant_nxt = pick;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        s_bus.req_valid        = 1'b1;
        s_bus.req_address      = m_bus.req_address[int'(grant)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        s_bus.req_write        = m_bus.req_write[grant];
        s_bus.req_data         = m_bus.req_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        m_bus.req_ready[grant] = s_bus.req_ready[0];
        if (s_bus.req_ready[0]) begin
          push           = 1'b1;
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Responses return in issue order, so the FIFO head names the owner.
  always_comb begin
    m_bus.resp_valid       = '0;
    m_bus.resp_valid[head] = s_bus.resp_valid[0] && !empty;
    s_bus.resp_ready       = !empty && m_bus.resp_ready[head];
    m_bus.resp_data        = s_bus.resp_data;
  end

  assign pop = s_bus.resp_valid[0] && s_bus.resp_ready[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_MASTERS - 1);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      if (push) begin
        tag_mem[wr_ptr] <= grant;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A response with no tag outstanding means the slave broke protocol.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(s_bus.resp_valid[0] && empty));
    end
  end
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: per-cycle vector table plus
// hand-written sequences for FIFO-full, response ordering and mid-grant reset.
module tb_memory_bus_arbiter;
  localparam int N  = 4;
  localparam int DW = 24;
  localparam int AW = 32;
  localparam int MO = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] outstanding;

  memory_bus_arbiter_if #(.LANES(N), .AW(AW), .DW(DW)) m_bus ();
  memory_bus_arbiter_if #(.LANES(1), .AW(AW), .DW(DW)) s_bus ();

  memory_bus_arbiter #(
    .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clock(clock), .reset(reset), .m_bus(m_bus), .s_bus(s_bus), .outstanding(outstanding)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  mv;
    logic        srr;
    logic        srv;
    logic [3:0]  mrr;
    logic [23:0] rdata;
    int          gm;
    logic [3:0]  emrv;
    logic        esrr;
    logic [2:0]  eout;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(logic rst, logic [3:0] mv, logic srr, logic srv, logic [3:0] mrr,
                              logic [23:0] rdata, int gm, logic [3:0] emrv, logic esrr,
                              logic [2:0] eout);
    vec_t v;
    v.rst = rst; v.mv = mv; v.srr = srr; v.srv = srv; v.mrr = mrr; v.rdata = rdata;
    v.gm = gm; v.emrv = emrv; v.esrr = esrr; v.eout = eout;
    return v;
  endfunction

  function automatic logic [AW-1:0] addr_of(int i);
    case (i)
      0:       return 32'h0000_0A00;
      1:       return 32'h0000_0B00;
      2:       return 32'h0000_1000;
      default: return 32'h0000_0D00;
    endcase
  endfunction

  function automatic logic [DW-1:0] data_of(int i);
    return 24'h5A0000 | DW'(i);
  endfunction

  function automatic logic write_of(int i);
    return i[0];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_req(int gm, logic srr);
    check("s_req_valid", 32'(s_bus.req_valid), (gm >= 0) ? 32'd1 : 32'd0);
    if (gm >= 0) begin
      check("s_req_address", s_bus.req_address, addr_of(gm));
      check("s_req_write", 32'(s_bus.req_write), 32'(write_of(gm)));
      check("s_req_data", 32'(s_bus.req_data), 32'(data_of(gm)));
      check("m_req_ready", 32'(m_bus.req_ready), srr ? (32'd1 << gm) : 32'd0);
    end else begin
      check("m_req_ready", 32'(m_bus.req_ready), 32'd0);
    end
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b1;
    m_bus.req_valid = '0;
    m_bus.resp_ready = 4'hF;
    s_bus.req_ready = 1'b0;
    s_bus.resp_valid = 1'b0;
    s_bus.resp_data = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Present a request from master m (called just after a negedge); ends on a negedge.
  task automatic issue(int m);
    logic got;
    got = 1'b0;
    m_bus.req_valid = 4'(1 << m);
    s_bus.req_ready = 1'b1;
    for (int k = 0; k < 6 && !got; k++) begin
      #1;
      if (s_bus.req_valid[0] && m_bus.req_ready[m]) begin
        got = 1'b1;
        check("issue_address", s_bus.req_address, addr_of(m));
      end
      @(negedge clock);
    end
    m_bus.req_valid = '0;
    s_bus.req_ready = 1'b0;
    check("issue_granted", 32'(got), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int issued;

    for (int i = 0; i < N; i++) begin
      m_bus.req_address[i*AW +: AW] = addr_of(i);
      m_bus.req_data[i*DW +: DW]    = data_of(i);
      m_bus.req_write[i]            = write_of(i);
    end
    m_bus.req_valid  = '0;
    m_bus.resp_ready = 4'hF;
    s_bus.req_ready  = 1'b0;
    s_bus.resp_valid = 1'b0;
    s_bus.resp_data  = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Idle after reset
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      #1;
      check_req(-1, 1'b0);
      check("idle_s_req_address", s_bus.req_address, 32'd0);
      check("idle_m_resp_valid", 32'(m_bus.resp_valid), 32'd0);
      check("idle_s_resp_ready", 32'(s_bus.resp_ready), 32'd0);
      check("idle_outstanding", 32'(outstanding), 32'd0);
    end

    // Single read from master 2, then round robin after a reset
    tab.push_back(mk(0, 4'b0100, 1, 0, 4'hF, 24'h0,      -1, 4'b0000, 0, 3'd0));
    tab.push_back(mk(0, 4'b0100, 1, 0, 4'hF, 24'h0,       2, 4'b0000, 0, 3'd0));
    tab.push_back(mk(0, 4'b0000, 1, 1, 4'hF, 24'hABCDEF, -1, 4'b0100, 1, 3'd1));
    tab.push_back(mk(0, 4'b0000, 1, 0, 4'hF, 24'h0,      -1, 4'b0000, 0, 3'd0));
    tab.push_back(mk(1, 4'b0000, 0, 0, 4'hF, 24'h0,      -1, 4'b0000, 0, 3'd0));
    tab.push_back(mk(0, 4'b1111, 1, 0, 4'hF, 24'h0,      -1, 4'b0000, 0, 3'd0));
    tab.push_back(mk(0, 4'b1111, 1, 0, 4'hF, 24'h0,       0, 4'b0000, 0, 3'd0));
    tab.push_back(mk(0, 4'b1111, 1, 1, 4'hF, 24'h000A01, -1, 4'b0001, 1, 3'd1));
    tab.push_back(mk(0, 4'b1111, 1, 0, 4'hF, 24'h0,       1, 4'b0000, 0, 3'd0));
    tab.push_back(mk(0, 4'b1111, 1, 1, 4'hF, 24'h000A02, -1, 4'b0010, 1, 3'd1));
    tab.push_back(mk(0, 4'b1111, 1, 0, 4'hF, 24'h0,       2, 4'b0000, 0, 3'd0));
    tab.push_back(mk(0, 4'b1111, 1, 1, 4'hF, 24'h000A03, -1, 4'b0100, 1, 3'd1));
    tab.push_back(mk(0, 4'b1111, 1, 0, 4'hF, 24'h0,       3, 4'b0000, 0, 3'd0));
    tab.push_back(mk(0, 4'b1111, 1, 1, 4'hF, 24'h000A04, -1, 4'b1000, 1, 3'd1));
    tab.push_back(mk(0, 4'b1111, 1, 0, 4'hF, 24'h0,       0, 4'b0000, 0, 3'd0));
    tab.push_back(mk(0, 4'b1111, 1, 1, 4'hF, 24'h000A05, -1, 4'b0001, 1, 3'd1));
    tab.push_back(mk(0, 4'b1111, 1, 0, 4'hF, 24'h0,       1, 4'b0000, 0, 3'd0));
    tab.push_back(mk(0, 4'b0000, 1, 1, 4'hF, 24'h000A06, -1, 4'b0010, 1, 3'd1));
    tab.push_back(mk(0, 4'b0000, 1, 0, 4'hF, 24'h0,      -1, 4'b0000, 0, 3'd0));

    foreach (tab[i]) begin
      @(negedge clock);
      reset            = tab[i].rst;
      m_bus.req_valid  = tab[i].mv;
      s_bus.req_ready  = tab[i].srr;
      s_bus.resp_valid = tab[i].srv;
      m_bus.resp_ready = tab[i].mrr;
      s_bus.resp_data  = tab[i].rdata;
      #1;
      if (!tab[i].rst) begin
        check_req(tab[i].gm, tab[i].srr);
        check("m_resp_valid", 32'(m_bus.resp_valid), 32'(tab[i].emrv));
        check("s_resp_ready", 32'(s_bus.resp_ready), 32'(tab[i].esrr));
        if (tab[i].emrv != 4'b0000) begin
          check("m_resp_data", 32'(m_bus.resp_data), 32'(tab[i].rdata));
        end
        check("outstanding", 32'(outstanding), 32'(tab[i].eout));
      end
    end
    reset = 1'b0;

    // FIFO full: slave never responds
    reset_dut();
    m_bus.req_valid = 4'hF;
    s_bus.req_ready = 1'b1;
    issued = 0;
    repeat (12) begin
      #1;
      if (s_bus.req_valid[0] && s_bus.req_ready[0]) issued++;
      @(negedge clock);
    end
    #1;
    check("full_issued", 32'(issued), 32'd4);
    check("full_outstanding", 32'(outstanding), 32'd4);
    check("full_no_s_req_valid", 32'(s_bus.req_valid), 32'd0);
    @(negedge clock);
    s_bus.resp_valid = 1'b1;
    s_bus.resp_data  = 24'h00BEEF;
    #1;
    check("full_resp_valid", 32'(m_bus.resp_valid), 32'b0001);
    check("full_resp_ready", 32'(s_bus.resp_ready), 32'd1);
    @(negedge clock);
    s_bus.resp_valid = 1'b0;
    #1;
    check("after_pop_outstanding", 32'(outstanding), 32'd3);
    issued = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      #1;
      if (s_bus.req_valid[0] && s_bus.req_ready[0]) issued++;
    end
    check("after_pop_issued", 32'(issued), 32'd1);
    check("refill_outstanding", 32'(outstanding), 32'd4);
    m_bus.req_valid = '0;

    // Response routing and head-of-line blocking
    reset_dut();
    issue(3);
    issue(1);
    s_bus.resp_valid = 1'b1;
    s_bus.resp_data  = 24'h000011;
    m_bus.resp_ready = 4'b0111;
    repeat (5) begin
      #1;
      check("hol_s_resp_ready", 32'(s_bus.resp_ready), 32'd0);
      check("hol_m_resp_valid", 32'(m_bus.resp_valid), 32'b1000);
      check("hol_outstanding", 32'(outstanding), 32'd2);
      @(negedge clock);
    end
    m_bus.resp_ready = 4'hF;
    #1;
    check("resp0_valid", 32'(m_bus.resp_valid), 32'b1000);
    check("resp0_data", 32'(m_bus.resp_data), 32'h11);
    check("resp0_ready", 32'(s_bus.resp_ready), 32'd1);
    @(negedge clock);
    s_bus.resp_data = 24'h000022;
    #1;
    check("resp1_valid", 32'(m_bus.resp_valid), 32'b0010);
    check("resp1_data", 32'(m_bus.resp_data), 32'h22);
    check("resp1_outstanding", 32'(outstanding), 32'd1);
    @(negedge clock);
    s_bus.resp_valid = 1'b0;
    #1;
    check("resp_done_outstanding", 32'(outstanding), 32'd0);

    // Reset while in GRANT with two tags outstanding
    reset_dut();
    issue(1);
    issue(2);
    m_bus.req_valid = 4'b1000;
    s_bus.req_ready = 1'b0;
    #1;
    @(negedge clock);
    #1;
    check("pre_reset_s_req_valid", 32'(s_bus.req_valid), 32'd1);
    check("pre_reset_outstanding", 32'(outstanding), 32'd2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_bus.req_valid = '0;
    #1;
    check("rst_s_req_valid", 32'(s_bus.req_valid), 32'd0);
    check("rst_s_req_address", s_bus.req_address, 32'd0);
    check("rst_m_req_ready", 32'(m_bus.req_ready), 32'd0);
    check("rst_m_resp_valid", 32'(m_bus.resp_valid), 32'd0);
    check("rst_s_resp_ready", 32'(s_bus.resp_ready), 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    @(negedge clock);
    m_bus.req_valid = 4'hF;
    s_bus.req_ready = 1'b1;
    #1;
    @(negedge clock);
    #1;
    check_req(0, 1'b1);
    @(negedge clock);
    m_bus.req_valid = '0;
    s_bus.req_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
